// File: rtl/logic_pipe.sv
// logic_pipe: 2-stage valid/ready pipelined AND/OR/XOR/ADD unit
// with a saturating count of completed output handshakes.
//
// Parameters:
//   WIDTH     operand/result width (>=1)
//   CNT_WIDTH transaction counter width (>=1)
//
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  operand handshake (a, b, op)
//   a, b               WIDTH-bit operands
//   op                 0=AND 1=OR 2=XOR 3=ADD
//   out_valid/out_ready result handshake
//   out_res            WIDTH-bit result
//   out_carry          ADD carry-out, 0 otherwise
//   out_zero           out_res == 0 (meaningful while out_valid)
//   cnt_clr            synchronous clear of txn_cnt (wins)
//   txn_cnt            saturating count of output handshakes
//
// Optional build macro LOGIC_PIPE_PARITY_EN adds out_parity = ^out_res,
// registered alongside out_res in stage 2.
module logic_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_res,
    output logic                 out_carry,
    output logic                 out_zero,
    input  logic                 cnt_clr,
`ifdef LOGIC_PIPE_PARITY_EN
    output logic                 out_parity,
`endif
    output logic [CNT_WIDTH-1:0] txn_cnt
);

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } op_e;

    // Stage 1: registered operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;

    // Stage 2: registered result
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_carry_q, s2_carry_d;
`ifdef LOGIC_PIPE_PARITY_EN
    logic             s2_par_q, s2_par_d;
`endif

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic out_fire;

    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    // Handshake / advance logic
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_fire  = in_valid && s1_adv;
        out_fire = s2_valid_q && out_ready;
    end

    // Stage 1 next state; data only captured on an actual accept
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_a_d  = a;
            s1_b_d  = b;
            s1_op_d = op_e'(op);
        end
    end

    // Result computation on stage-1 contents
    always_comb begin
        alu_sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (s1_op_q)
            OP_AND: alu_res = s1_a_q & s1_b_q;
            OP_OR:  alu_res = s1_a_q | s1_b_q;
            OP_XOR: alu_res = s1_a_q ^ s1_b_q;
            OP_ADD: begin
                alu_res   = alu_sum[WIDTH-1:0];
                alu_carry = alu_sum[WIDTH];
            end
        endcase
    end

    // Stage 2 next state; result held while stalled, and left
    // untouched by bubbles so outputs stay at their last value.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_carry_d = s2_carry_q;
`ifdef LOGIC_PIPE_PARITY_EN
        s2_par_d   = s2_par_q;
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            s2_res_d   = alu_res;
            s2_carry_d = alu_carry;
`ifdef LOGIC_PIPE_PARITY_EN
            s2_par_d   = ^alu_res;
`endif
        end
    end

    // Saturating counter; clear takes priority over a handshake
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_carry_q <= 1'b0;
`ifdef LOGIC_PIPE_PARITY_EN
            s2_par_q   <= 1'b0;
`endif
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_carry_q <= s2_carry_d;
`ifdef LOGIC_PIPE_PARITY_EN
            s2_par_q   <= s2_par_d;
`endif
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_res    = s2_res_q;
    assign out_carry  = s2_carry_q;
    assign out_zero   = (s2_res_q == '0);
    assign txn_cnt    = cnt_q;
`ifdef LOGIC_PIPE_PARITY_EN
    assign out_parity = s2_par_q;
`endif

endmodule
